// File: rtl/gact_job_scheduler_if.sv
// gact_job_scheduler_if: host-side job request channel and
// tagged response channel of the GACT job scheduler.
interface gact_job_scheduler_if #(
  parameter int N_REQ      = 4,
  parameter int R_LEN      = 128,
  parameter int Q_LEN      = 128,
  parameter int SCORE_BITS = 12
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*2*R_LEN-1:0] req_R;
  logic [N_REQ*2*Q_LEN-1:0] req_Q;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [IDW-1:0]           resp_id;
  logic [SCORE_BITS-1:0]    resp_score;
  logic                     resp_err;

  modport master (
    output req_valid, req_R, req_Q, resp_ready,
    input  req_ready, resp_valid, resp_id,
    input  resp_score, resp_err
  );

  modport slave (
    input  req_valid, req_R, req_Q, resp_ready,
    output req_ready, resp_valid, resp_id,
    output resp_score, resp_err
  );
endinterface

// File: rtl/gact_job_scheduler.sv
// gact_job_scheduler: round-robin front end sharing one GACT core
// between N_REQ job queues, with watchdog abort and tagged responses.
module gact_job_scheduler #(
  parameter int N_REQ      = 4,
  parameter int R_LEN      = 128,
  parameter int Q_LEN      = 128,
  parameter int SCORE_BITS = 12,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  gact_job_scheduler_if.slave   host,
  output logic                  core_clr,
  output logic                  core_valid,
  output logic [2*R_LEN-1:0]    core_R,
  output logic [2*Q_LEN-1:0]    core_Q,
  input  logic                  core_done,
  input  logic [SCORE_BITS-1:0] core_score,
  output logic                  busy,
  output logic [15:0]           job_cnt,
  output logic [7:0]            err_cnt
);
  localparam int IDW = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] idx;
  logic           gnt_hit;
  logic           accept;
  logic [WDW-1:0] wdog;
  logic           wdog_exp;

  // First valid requester at or after rr_ptr; the index wraps mod N_REQ.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!gnt_hit && host.req_valid[idx]) begin
        gnt_hit = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign accept   = (state == S_IDLE) && gnt_hit;
  assign wdog_exp = (wdog == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (gnt_hit) state_nx = S_CLEAR;
      S_CLEAR:  state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT:   if (core_done || wdog_exp) state_nx = S_RESP;
      S_RESP:   if (host.resp_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    host.req_ready  = '0;
    host.resp_valid = 1'b0;
    core_clr        = 1'b0;
    core_valid      = 1'b0;
    busy            = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (gnt_hit) host.req_ready = N_REQ'(1) << gnt_id;
      end
      S_CLEAR:  core_clr = 1'b1;
      S_LAUNCH: core_valid = 1'b1;
      S_RESP:   host.resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Watchdog reads 0 during LAUNCH, so it equals cycles since LAUNCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog <= '0;
    end else if (state == S_LAUNCH || state == S_WAIT) begin
      wdog <= wdog + WDW'(1);
    end else begin
      wdog <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr          <= '0;
      core_R          <= '0;
      core_Q          <= '0;
      host.resp_id    <= '0;
      host.resp_score <= '0;
      host.resp_err   <= 1'b0;
      job_cnt         <= '0;
      err_cnt         <= '0;
    end else begin
      if (accept) begin
        core_R       <= host.req_R[int'(gnt_id)*2*R_LEN +: 2*R_LEN];
        core_Q       <= host.req_Q[int'(gnt_id)*2*Q_LEN +: 2*Q_LEN];
        host.resp_id <= gnt_id;
        rr_ptr       <= gnt_id + IDW'(1);
      end
      if (state == S_WAIT) begin
        if (core_done) begin
          host.resp_score <= core_score;
          host.resp_err   <= 1'b0;
          if (job_cnt != 16'hFFFF) job_cnt <= job_cnt + 16'd1;
        end else if (wdog_exp) begin
          host.resp_score <= '0;
          host.resp_err   <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_gact_job_scheduler.sv
// tb_gact_job_scheduler: table, hand-written and randomized jobs
// against a behavioural core and a round-robin reference model.
module tb_gact_job_scheduler;
  localparam int N  = 4;
  localparam int RL = 128;
  localparam int QL = 128;
  localparam int SB = 12;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          core_clr;
  logic          core_valid;
  logic [2*RL-1:0] core_R;
  logic [2*QL-1:0] core_Q;
  logic          core_done;
  logic [SB-1:0] core_score;
  logic          busy;
  logic [15:0]   job_cnt;
  logic [7:0]    err_cnt;

  gact_job_scheduler_if #(
    .N_REQ(N), .R_LEN(RL), .Q_LEN(QL), .SCORE_BITS(SB)
  ) bus ();

  gact_job_scheduler #(
    .N_REQ(N), .R_LEN(RL), .Q_LEN(QL),
    .SCORE_BITS(SB), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host(bus),
    .core_clr(core_clr),
    .core_valid(core_valid),
    .core_R(core_R),
    .core_Q(core_Q),
    .core_done(core_done),
    .core_score(core_score),
    .busy(busy),
    .job_cnt(job_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int m_ptr = 0;
  int exp_jobs = 0;
  int exp_errs = 0;
  int core_delay = 1;
  logic [SB-1:0] core_score_val = '0;
  logic [SB-1:0] spur_score = '0;
  int spur_cnt = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Behavioural core: done pulse core_delay cycles after core_valid,
  // abandoned if the scheduler leaves WAIT first.
  initial begin
    int spur_seen;
    int n;
    bit ab;
    spur_seen  = 0;
    core_done  = 1'b0;
    core_score = '0;
    forever begin
      @(negedge clk);
      core_done  = 1'b0;
      core_score = SB'($urandom);
      if (spur_cnt != spur_seen) begin
        spur_seen  = spur_cnt;
        core_done  = 1'b1;
        core_score = spur_score;
      end else if (core_valid) begin
        n  = 0;
        ab = 1'b0;
        while (n < core_delay && !ab) begin
          @(negedge clk);
          core_score = SB'($urandom);
          n++;
          if (bus.resp_valid || !busy) ab = 1'b1;
        end
        if (!ab) begin
          core_done  = 1'b1;
          core_score = core_score_val;
        end
      end
    end
  end

  // Reference arbiter: valid requester with the smallest
  // circular distance from the pointer.
  function automatic int model_grant(input logic [N-1:0] mask,
                                     input int ptr);
    int best;
    int bd;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && ((i - ptr + N) % N) < bd) begin
        bd   = (i - ptr + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic fill_data(input bit zero);
    for (int w = 0; w < N*2*RL/32; w++)
      bus.req_R[w*32 +: 32] = zero ? 32'd0 : $urandom;
    for (int w = 0; w < N*2*QL/32; w++)
      bus.req_Q[w*32 +: 32] = zero ? 32'd0 : $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_core_clr", core_clr, 0);
    check("rst_core_valid", core_valid, 0);
    check("rst_core_R", core_R, 0);
    check("rst_core_Q", core_Q, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_resp_score", bus.resp_score, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_job_cnt", job_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    m_ptr    = 0;
    exp_jobs = 0;
    exp_errs = 0;
  endtask

  task automatic run_job(input logic [N-1:0] mask,
                         input logic [N-1:0] exp_gnt,
                         input int delay, input logic [SB-1:0] score,
                         input int bp, input logic [N-1:0] pend,
                         input bit zdata);
    int gid;
    int lat;
    int n;
    int exp_lat;
    bit exp_err;
    logic [SB-1:0] exp_sc;
    logic [2*RL-1:0] exp_r;
    logic [2*QL-1:0] exp_q;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 0);
    gid = 0;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) gid = i;
    fill_data(zdata);
    core_delay     = delay;
    core_score_val = score;
    bus.req_valid  = mask;
    #1;
    check("req_ready", bus.req_ready, exp_gnt);
    exp_r = bus.req_R[gid*2*RL +: 2*RL];
    exp_q = bus.req_Q[gid*2*QL +: 2*QL];
    @(negedge clk);
    bus.req_valid = '0;
    check("clr_t1", core_clr, 1);
    check("valid_t1", core_valid, 0);
    @(negedge clk);
    check("clr_t2", core_clr, 0);
    check("valid_t2", core_valid, 1);
    check("core_R", core_R, exp_r);
    check("core_Q", core_Q, exp_q);
    exp_err = (delay > TO - 1);
    exp_lat = exp_err ? TO : delay + 1;
    exp_sc  = exp_err ? '0 : score;
    lat = 0;
    while (!bus.resp_valid && lat < TO + 50) begin
      bus.resp_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("resp_latency", lat, exp_lat);
    check("resp_id", bus.resp_id, gid);
    check("resp_err", bus.resp_err, exp_err);
    check("resp_score", bus.resp_score, exp_sc);
    if (exp_err) exp_errs++;
    else         exp_jobs++;
    bus.resp_ready = 1'b0;
    bus.req_valid  = pend;
    for (int c = 0; c < bp; c++) begin
      #1;
      check("bp_valid", bus.resp_valid, 1);
      check("bp_id", bus.resp_id, gid);
      check("bp_score", bus.resp_score, exp_sc);
      check("bp_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("resp_done", bus.resp_valid, 0);
    check("job_cnt", job_cnt, exp_jobs);
    check("err_cnt", err_cnt, exp_errs);
    m_ptr = (gid + 1) % N;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] gnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [N-1:0] mk;
    int g;
    int g2;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    bus.req_R      = '0;
    bus.req_Q      = '0;

    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b1000};
    tbl[8]  = '{4'b1101, 4'b0001};
    tbl[9]  = '{4'b1101, 4'b0100};
    tbl[10] = '{4'b1101, 4'b1000};
    tbl[11] = '{4'b0110, 4'b0010};
    tbl[12] = '{4'b0110, 4'b0100};
    tbl[13] = '{4'b0110, 4'b0010};
    tbl[14] = '{4'b1000, 4'b1000};
    tbl[15] = '{4'b0001, 4'b0001};
    tbl[16] = '{4'b0011, 4'b0010};
    tbl[17] = '{4'b0001, 4'b0001};

    do_reset();
    repeat (3) begin
      @(negedge clk);
      #1;
      check("idle_no_req", bus.req_ready, 0);
      check("idle_busy", busy, 0);
    end

    // Single job from requester 2, all-A sequences, slow core.
    run_job(4'b0100, 4'b0100, 260, 12'h100, 0, '0, 1'b1);

    // Arbitration table from a fresh pointer.
    do_reset();
    foreach (tbl[i])
      run_job(tbl[i].mask, tbl[i].gnt, $urandom_range(1, 8),
              SB'($urandom), 0, '0, 1'b0);

    // Back-pressure with a job pending behind the response.
    mk = 4'b0010;
    g  = model_grant(mk, m_ptr);
    run_job(mk, N'(1) << g, 5, 12'h3C5, 50, 4'b1001, 1'b0);
    g2 = model_grant(4'b1001, m_ptr);
    #1;
    check("bp_next_idle", busy, 0);
    check("bp_next_grant", bus.req_ready, N'(1) << g2);
    run_job(4'b1001, N'(1) << g2, 3, 12'h0AA, 0, '0, 1'b0);

    // Spurious core_done while idle.
    spur_score = 12'hABC;
    spur_cnt++;
    repeat (4) begin
      @(negedge clk);
      check("spur_resp", bus.resp_valid, 0);
      check("spur_busy", busy, 0);
    end
    check("spur_job_cnt", job_cnt, exp_jobs);
    check("spur_err_cnt", err_cnt, exp_errs);

    // Watchdog abort, then done on the final watchdog cycle.
    do_reset();
    run_job(4'b0001, 4'b0001, 5000, 12'h777, 0, '0, 1'b0);
    mk = 4'b0011;
    g  = model_grant(mk, m_ptr);
    run_job(mk, N'(1) << g, TO - 1, 12'h5A5, 0, '0, 1'b0);

    // Randomized jobs against the reference arbiter.
    for (int j = 0; j < 40; j++) begin
      mk = N'($urandom_range(1, (1 << N) - 1));
      g  = model_grant(mk, m_ptr);
      run_job(mk, N'(1) << g, $urandom_range(1, 30), SB'($urandom),
              ($urandom % 4 == 0) ? $urandom_range(1, 6) : 0,
              '0, 1'b0);
    end

    // Reset while the core is running.
    fill_data(1'b0);
    core_delay    = 200;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    bus.req_valid = '0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    do_reset();
    repeat (20) begin
      @(negedge clk);
      check("post_reset_resp", bus.resp_valid, 0);
    end
    run_job(4'b1111, 4'b0001, 4, 12'h055, 0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gact_job_scheduler.md
Name: gact_job_scheduler

Overview:
- Shares one GACT systolic alignment core between N_REQ requesters.
- Round-robin arbitration picks one job at a time. The block clears the core, launches the job, and waits for core done under a watchdog.
- The score or an error returns on a single response channel tagged with the requester id.
- Sits between the host/DMA job queues and the GACT core. At top level the core reset pin is driven by reset OR core_clr.

Parameters:
- N_REQ, 4, number of requesters (power of 2, at least 2)
- R_LEN, 128, reference length in 2-bit bases
- Q_LEN, 128, query length in 2-bit bases
- SCORE_BITS, 12, score width
- TIMEOUT, 1024, maximum WAIT cycles before abort (must be greater than 2*Q_LEN+8)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  N_REQ  per-requester job valid
- req_ready  out  N_REQ  one-hot accept
- req_R  in  N_REQ*2*R_LEN  per-requester reference; slot i at bits [i*2*R_LEN +: 2*R_LEN]
- req_Q  in  N_REQ*2*Q_LEN  per-requester query; packed the same way
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  log2(N_REQ)  requester the response belongs to
- resp_score  out  SCORE_BITS  alignment score
- resp_err  out  1  watchdog abort flag
- core_clr  out  1  core re-initialise pulse
- core_valid  out  1  core input_valid
- core_R  out  2*R_LEN  core reference
- core_Q  out  2*Q_LEN  core query
- core_done  in  1  core done pulse
- core_score  in  SCORE_BITS  core score
- busy  out  1  high whenever state is not IDLE
- job_cnt  out  16  completed jobs, saturating
- err_cnt  out  8  aborted jobs, saturating

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, R/Q holding registers 0. Reset mid-job abandons the job silently; no response is issued.
- States: IDLE, CLEAR, LAUNCH, WAIT, RESP.
- IDLE: req_ready is combinational and one-hot. It selects the first requester with req_valid set, searching rr_ptr, rr_ptr+1, … modulo N_REQ. On that cycle:
  - capture req_R/req_Q slice into core_R/core_Q;
  - capture the grant id;
  - rr_ptr <= grant+1 (mod N_REQ);
  - go to CLEAR.
- IDLE with no req_valid: req_ready stays 0.
- req_ready is 0 in every other state. A requester keeps its job presented until accepted.
- CLEAR: core_clr=1 for exactly one cycle; then LAUNCH.
- LAUNCH: core_valid=1 for exactly one cycle; wdog cleared to 0; then WAIT.
- core_R/core_Q hold stable from CLEAR until the next accept.
- WAIT: wdog increments each cycle.
  - core_done=1: register resp_score<=core_score (sampled that cycle), resp_err<=0, job_cnt+1; go to RESP.
  - else if wdog==TIMEOUT-1: resp_score<=0, resp_err<=1, err_cnt+1; go to RESP.
  - core_done wins if both occur in the same cycle.
- RESP: resp_valid=1. resp_id, resp_score and resp_err are held stable until resp_ready=1; on that cycle return to IDLE.
  - A new job can be accepted no earlier than the cycle after the handshake.
  - resp_ready=1 while resp_valid=0 has no effect.
- core_done outside WAIT is ignored and is not counted.
- Counters saturate: job_cnt at 0xFFFF, err_cnt at 0xFF.
- Latency: accept at cycle t; core_clr at t+1; core_valid at t+2; resp_valid one cycle after the core_done cycle.
- Round-robin fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0…; no requester waits more than N_REQ-1 jobs.

Test Plan:
- Single job: requester 2 submits R=Q=all-A with a behavioural core that gives done after 260 cycles with score 0x100.
  - Expect req_ready=0100 for one cycle.
  - Expect core_clr at t+1 and core_valid at t+2.
  - Expect resp_valid with id=2, score=0x100, err=0; job_cnt=1.
- Arbitration: all 4 req_valid held high, resp_ready=1, 8 jobs.
  - Expect grant order 0,1,2,3,0,1,2,3 and job_cnt=8.
  - Between the two bursts, drop req_valid[1] after its first grant; the second pass must be 0,2,3.
- Timeout: core never asserts done.
  - Expect resp_valid exactly TIMEOUT cycles after LAUNCH, with err=1, score=0; err_cnt=1, job_cnt=0.
- Back-pressure: resp_ready held 0 for 50 cycles.
  - resp_valid, id and score stay stable; req_ready stays 0 despite a pending req_valid.
  - After resp_ready=1 for one cycle, the next job is accepted the following cycle.
- Spurious/simultaneous events:
  - core_done pulsed in IDLE: no response, counts unchanged.
  - core_done on the same cycle wdog reaches TIMEOUT-1: err=0, score captured.
- Reset mid-WAIT: assert reset asynchronously between edges.
  - All outputs go to 0 immediately, with no response.
  - After release, rr_ptr=0 and requester 0 is granted first.
